signed_div: RTL

- Iterative signed integer divider; the inverse operation of signed_mult in the DDS datapath.
- Used for gain and phase-increment normalisation, where a quotient is needed occasionally rather than every sample.
- Uses radix-2 restoring division on magnitudes, one quotient bit per clock-enabled cycle, then applies a sign fix-up.
- Uses a start/busy/done handshake and shares the datapath clock enable `ce`.

---
 rtl/signed_div.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/signed_div.sv
// signed_div: iterative radix-2 restoring signed divider with start/busy/done
// handshake and a shared clock enable. Magnitudes are divided one quotient bit
// per enabled cycle, then a FIX state applies the signs and the special cases
// (divide by zero, -2^(N-1) / -1 overflow).
//
// Optional feature macro: SIGNED_DIV_REMAINDER_EN
//   defined   - remainder output carries the signed remainder (sign of dividend)
//   undefined - remainder output is tied to 0 and its fix-up/register is not built
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   ce            clock enable; every register holds when low (reset still wins)
//   start         division request, accepted only in IDLE with ce=1
//   dividend      signed numerator, captured on acceptance
//   divisor       signed denominator, captured on acceptance
//   busy          high from acceptance until FIX completes
//   done          one-enabled-cycle result strobe
//   quotient      signed quotient, truncated toward zero
//   remainder     signed remainder (or 0 when the feature is disabled)
//   div_by_zero   divisor was zero (valid with done)
//   overflow      -2^(N-1) / -1 saturated (valid with done)
module signed_div #(
  parameter int unsigned N = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero,
  output logic         overflow
);

  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [N-1:0] Q_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] Q_MIN = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  dvd_q, dvd_d;     // dividend magnitude, becomes quotient magnitude
  logic [N-1:0]  dvs_q, dvs_d;     // divisor magnitude
  logic [N:0]    rem_q, rem_d;     // partial remainder
  logic          dvd_neg_q, dvd_neg_d;
  logic          dvs_neg_q, dvs_neg_d;
  logic          dvs_zero_q, dvs_zero_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [N-1:0]  quotient_q, quotient_d;
  logic          dz_q, dz_d;
  logic          ovf_q, ovf_d;

  logic [N:0]    rem_sh;
  logic [N:0]    rem_sub;
  logic          ge;
  logic          q_neg;

`ifdef SIGNED_DIV_REMAINDER_EN
  logic [N-1:0]  remainder_q, remainder_d;
`endif

  // One restoring step: shift in the next dividend bit, trial-subtract divisor
  always_comb begin
    rem_sh  = (N+1)'({rem_q, dvd_q[N-1]});
    ge      = (rem_sh >= {1'b0, dvs_q});
    rem_sub = rem_sh - {1'b0, dvs_q};
    q_neg   = dvd_neg_q ^ dvs_neg_q;
  end

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    dvd_neg_d  = dvd_neg_q;
    dvs_neg_d  = dvs_neg_q;
    dvs_zero_d = dvs_zero_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    quotient_d = quotient_q;
    dz_d       = dz_q;
    ovf_d      = ovf_q;
`ifdef SIGNED_DIV_REMAINDER_EN
    remainder_d = remainder_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_neg_d  = dividend[N-1];
          dvs_neg_d  = divisor[N-1];
          dvs_zero_d = (divisor == '0);
          dvd_d      = dividend[N-1] ? N'(-dividend) : dividend;
          dvs_d      = divisor[N-1]  ? N'(-divisor)  : divisor;
          rem_d      = '0;
          cnt_d      = CW'(N);
          busy_d     = 1'b1;
          state_d    = S_CALC;
        end
      end
      S_CALC: begin
        // Counter hits zero after N iterations; one more cycle hands off to FIX
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          rem_d = ge ? rem_sub : rem_sh;
          dvd_d = {dvd_q[N-2:0], ge};
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_FIX: begin
        if (dvs_zero_q) begin
          quotient_d = dvd_neg_q ? Q_MIN : Q_MAX;
          dz_d       = 1'b1;
          ovf_d      = 1'b0;
        end else if (!q_neg && dvd_q[N-1]) begin
          // Positive magnitude 2^(N-1) only arises from -2^(N-1) / -1
          quotient_d = Q_MAX;
          dz_d       = 1'b0;
          ovf_d      = 1'b1;
        end else begin
          quotient_d = q_neg ? N'(-dvd_q) : dvd_q;
          dz_d       = 1'b0;
          ovf_d      = 1'b0;
        end
`ifdef SIGNED_DIV_REMAINDER_EN
        // With a zero divisor the partial remainder ends up equal to |dividend|
        remainder_d = dvd_neg_q ? N'(-rem_q[N-1:0]) : rem_q[N-1:0];
`endif
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset overrides ce
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      dvd_neg_q  <= 1'b0;
      dvs_neg_q  <= 1'b0;
      dvs_zero_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      quotient_q <= '0;
      dz_q       <= 1'b0;
      ovf_q      <= 1'b0;
`ifdef SIGNED_DIV_REMAINDER_EN
      remainder_q <= '0;
`endif
    end else if (ce) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      dvd_neg_q  <= dvd_neg_d;
      dvs_neg_q  <= dvs_neg_d;
      dvs_zero_q <= dvs_zero_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      quotient_q <= quotient_d;
      dz_q       <= dz_d;
      ovf_q      <= ovf_d;
`ifdef SIGNED_DIV_REMAINDER_EN
      remainder_q <= remainder_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign div_by_zero = dz_q;
  assign overflow    = ovf_q;
`ifdef SIGNED_DIV_REMAINDER_EN
  assign remainder   = remainder_q;
`else
  assign remainder   = '0;
`endif

endmodule
